phaser_axil_regs: RTL and testbench
===================================

PHASER_AXIL_REGS -- requirements
Module: phaser_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering four 32-bit registers.
REQ-003 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock. All logic is rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port S_AXI_AWADDR, input, 4 bits: write address.
REQ-006 SHALL have port S_AXI_AWPROT, input, 3 bits: ignored.
REQ-007 SHALL have ports S_AXI_AWVALID (input, 1 bit) and S_AXI_AWREADY (output, 1 bit).
REQ-008 SHALL have ports S_AXI_WDATA (input, 32 bits), S_AXI_WSTRB (input, 4 bits), S_AXI_WVALID (input, 1 bit) and S_AXI_WREADY (output, 1 bit).
REQ-009 SHALL have ports S_AXI_BRESP (output, 2 bits), S_AXI_BVALID (output, 1 bit) and S_AXI_BREADY (input, 1 bit).
REQ-010 SHALL have ports S_AXI_ARADDR (input, 4 bits), S_AXI_ARPROT (input, 3 bits, ignored), S_AXI_ARVALID (input, 1 bit) and S_AXI_ARREADY (output, 1 bit).
REQ-011 SHALL have ports S_AXI_RDATA (output, 32 bits), S_AXI_RRESP (output, 2 bits), S_AXI_RVALID (output, 1 bit) and S_AXI_RREADY (input, 1 bit).
REQ-012 SHALL have outputs reg0_o, reg1_o, reg2_o and reg3_o, 32 bits each: current register contents, fed to the phaser core.
REQ-013 SHALL have output reg_wr_o, 4 bits: one-hot, one-cycle pulse marking which register was written.

Function
REQ-014 SHALL decode register index from address bits [3:2]; bits [1:0] are ignored; every address maps to a register (no decode error).
REQ-015 SHALL drive BRESP and RRESP to 2'b00 (OKAY) at all times.
REQ-016 Write accept: SHALL set AWREADY and WREADY high together for exactly one cycle, in the cycle after a cycle where AWVALID=1, WVALID=1, AWREADY=0 and BVALID=0.
REQ-017 SHALL NOT accept an address without its data, or data without its address; a lone AWVALID or lone WVALID waits.
REQ-018 At the handshake edge, SHALL update each byte k of the addressed register where WSTRB[k]=1 and keep bytes where WSTRB[k]=0; WSTRB=0 leaves the register unchanged but is still acknowledged.
REQ-019 SHALL assert the matching reg_wr_o bit for one cycle in the cycle after the handshake edge, coincident with updated regN_o.
REQ-020 SHALL raise BVALID in the cycle after the handshake and hold it until BVALID and BREADY are both high at an edge; no new write is accepted while BVALID=1 (one outstanding write).
REQ-021 Read accept: SHALL set ARREADY high for one cycle in the cycle after a cycle where ARVALID=1, ARREADY=0 and RVALID=0.
REQ-022 SHALL capture RDATA from the addressed register at the AR handshake edge, raise RVALID the next cycle, and hold RDATA and RVALID stable until RREADY=1 at an edge (one outstanding read).
REQ-023 Read and write channels SHALL operate independently and concurrently.
REQ-024 If a read and a write handshake to the same register occur at the same edge, RDATA SHALL return the pre-write value.
REQ-025 Best-case latency: write 2 cycles from valid to BVALID; read 2 cycles from ARVALID to RVALID.
REQ-026 Back-to-back transfers SHALL be possible every 3 cycles per channel when BREADY/RREADY are held high.

Reset
REQ-027 While S_AXI_ARESETN=0, SHALL immediately force the following low/zero regardless of clock: AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, reg_wr_o, and reg0_o..reg3_o (32'h0).
REQ-028 Reset asserted mid-transaction SHALL abandon that transaction (no response issued afterwards); the first accept after release is no earlier than the second rising edge.

Verification
REQ-029 Write 32'h1, 32'h2, 32'h3, 32'h4 to 0x0, 0x4, 0x8, 0xC with WSTRB=4'hF, then read back -> RDATA = 1, 2, 3, 4, all responses OKAY, and reg_wr_o pulses 4'b0001, 4'b0010, 4'b0100, 4'b1000.
REQ-030 Write reg1=32'hAABBCCDD, then write 32'h11223344 with WSTRB=4'b0101 to 0x4 -> reg1_o = 32'hAA22CC44.
REQ-031 AWVALID raised 3 cycles before WVALID -> no AWREADY until both are high; exactly one write; BVALID 2 cycles after WVALID.
REQ-032 Hold BREADY=0 for 5 cycles with a second write pending -> BVALID stays high, the second write is not accepted until the B handshake, then it completes with the correct data.
REQ-033 Hold RREADY=0 for 4 cycles while reading reg2=32'h3 and writing reg2=32'h9 -> RDATA stays 32'h3 until accepted; a subsequent read returns 32'h9.
REQ-034 Assert reset while BVALID=1 and reg0=32'h5 -> BVALID=0 and reg0_o=0 immediately; no B response after release.

Source files
------------

// File: rtl/phaser_axil_regs.sv
// phaser_axil_regs: AXI4-Lite slave holding the four 32-bit phaser control
// registers. At most one write and one read are in flight at a time. The write
// and read channels run independently of each other.
module phaser_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   // write response channel
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   // register contents towards the phaser core
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
   output logic [3:0]                      reg_wr_o
);

   localparam int NUM_REGS = 4;
   localparam int ADDR_LSB = 2;
   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;
   typedef logic [1:0]                    reg_idx_t;

   // ------------------------------------------------------------------
   // Write-channel state
   // ------------------------------------------------------------------
   logic     wr_accept_q, wr_accept_d;   // drives AWREADY and WREADY together
   logic     bvalid_q,    bvalid_d;
   logic     wr_fire;
   reg_idx_t wr_idx;
   word_t    regs_q [NUM_REGS];
   word_t    regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;

   // ------------------------------------------------------------------
   // Read-channel state
   // ------------------------------------------------------------------
   logic     arready_q, arready_d;
   logic     rvalid_q,  rvalid_d;
   word_t    rdata_q,   rdata_d;
   logic     rd_fire;
   reg_idx_t rd_idx;

   // Protection bits and the byte offset inside a word carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   assign wr_idx  = S_AXI_AWADDR[ADDR_LSB +: 2];
   assign rd_idx  = S_AXI_ARADDR[ADDR_LSB +: 2];

   // A write completes on the edge where the accept pulse meets both valids.
   assign wr_fire = wr_accept_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_fire = arready_q & S_AXI_ARVALID;

   // Write accept and response: accept only when address and data are both
   // present and no response is still waiting for the master.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      wr_accept_d = 1'b0;
      bvalid_d    = bvalid_q;

      if (S_AXI_AWVALID && S_AXI_WVALID && !wr_accept_q && !bvalid_q) begin
         wr_accept_d = 1'b1;
      end

      if (wr_fire) begin
         bvalid_d = 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   // Register file update: merge the strobed bytes into the addressed word
   // and flag which register changed for the core.
   always_comb begin
      regs_d   = regs_q;
      reg_wr_d = '0;

      if (wr_fire) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (S_AXI_WSTRB[b]) begin
               regs_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
         end
         reg_wr_d[wr_idx] = 1'b1;
      end
   end

   // Read accept and data hold: RDATA is sampled from the pre-edge register
   // contents, so a write landing on the same edge is not yet visible.
   always_comb begin
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;

      if (S_AXI_ARVALID && !arready_q && !rvalid_q) begin
         arready_d = 1'b1;
      end

      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[rd_idx];
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   // Write-channel and register-file flops; reset abandons any write in flight.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_accept_q <= 1'b0;
         bvalid_q    <= 1'b0;
         reg_wr_q    <= '0;
         // NOTE: the register file is a handful of flops feeding the core
         // directly, not a RAM, so it is cleared by reset like any other state.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         wr_accept_q <= wr_accept_d;
         bvalid_q    <= bvalid_d;
         reg_wr_q    <= reg_wr_d;
         regs_q      <= regs_d;
      end
   end

   // Read-channel flops; reset abandons any read in flight.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign S_AXI_AWREADY = wr_accept_q;
   assign S_AXI_WREADY  = wr_accept_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;

   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;

   assign reg0_o   = regs_q[0];
   assign reg1_o   = regs_q[1];
   assign reg2_o   = regs_q[2];
   assign reg3_o   = regs_q[3];
   assign reg_wr_o = reg_wr_q;

endmodule

// File: tb/tb_phaser_axil_regs.sv
// tb_phaser_axil_regs: self-checking bench for the phaser AXI4-Lite register
// block. Read data and register-write pulses are checked against scoreboard
// queues that are filled when the stimulus is driven.
module tb_phaser_axil_regs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] reg0, reg1, reg2, reg3;
   logic [3:0]  reg_wr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rd_exp_q [$];
   logic [3:0]  wr_exp_q [$];
   logic [3:0]  mon_exp;

   always #5 clk = ~clk;

   phaser_axil_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg0_o        (reg0),
      .reg1_o        (reg1),
      .reg2_o        (reg2),
      .reg3_o        (reg3),
      .reg_wr_o      (reg_wr)
   );

   // Register-write pulse monitor: every pulse must match the next expected one.
   always @(negedge clk) begin
      if (rst_n && reg_wr !== 4'b0000) begin
         n_checks++;
         if (wr_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL reg_wr_unexpected: got %b, expected no pulse", reg_wr);
         end else begin
            mon_exp = wr_exp_q.pop_front();
            if (reg_wr !== mon_exp) begin
               n_fail++;
               $display("FAIL reg_wr_pulse: got %b, expected %b", reg_wr, mon_exp);
            end
         end
      end
   end

   // Complete AXI write with BREADY held high; checks BRESP.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int cyc;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      wr_exp_q.push_back(4'b0001 << addr[3:2]);
      cyc = 0;
      while (!(awready && wready) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20) begin
         n_checks++; n_fail++;
         $display("FAIL write_accept_timeout: addr %h not accepted in 20 cycles", addr);
      end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      cyc = 0;
      while (!bvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (!bvalid || bresp !== 2'b00) begin
         n_fail++;
         $display("FAIL write_bresp: bvalid %b bresp %b, expected 1 / 00", bvalid, bresp);
      end
      @(negedge clk);
   endtask

   // Complete AXI read with RREADY held high; RDATA checked via the scoreboard.
   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
      int cyc;
      logic [31:0] e;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      rd_exp_q.push_back(exp);
      cyc = 0;
      while (!arready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      cyc = 0;
      while (!rvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      e = rd_exp_q.pop_front();
      n_checks++;
      if (!rvalid || rdata !== e || rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL read_data addr %h: rvalid %b rdata %h rresp %b, expected 1 %h 00",
                  addr, rvalid, rdata, rresp, e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0 ||
          reg_wr !== 4'h0 || {reg0, reg1, reg2, reg3} !== 128'h0 ||
          bresp !== 2'b00 || rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_state: ready %b%b%b valid %b%b rdata %h regs %h %h %h %h, expected all zero",
                  awready, wready, arready, bvalid, rvalid, rdata, reg0, reg1, reg2, reg3);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_rw();
      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h2, 4'hF);
      axi_write(4'h8, 32'h3, 4'hF);
      axi_write(4'hC, 32'h4, 4'hF);
      n_checks++;
      if ({reg0, reg1, reg2, reg3} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin
         n_fail++;
         $display("FAIL basic_regs: got %h %h %h %h, expected 1 2 3 4", reg0, reg1, reg2, reg3);
      end
      axi_read(4'h0, 32'h1);
      axi_read(4'h4, 32'h2);
      axi_read(4'h8, 32'h3);
      axi_read(4'hC, 32'h4);
      axi_read(4'hB, 32'h3);   // low address bits ignored
   endtask

   task automatic test_strobe();
      axi_write(4'h4, 32'hAABBCCDD, 4'hF);
      axi_write(4'h4, 32'h11223344, 4'b0101);
      n_checks++;
      if (reg1 !== 32'hAA22CC44) begin
         n_fail++;
         $display("FAIL strobe_merge: reg1 %h, expected aa22cc44", reg1);
      end
      axi_write(4'h5, 32'hFFFFFFFF, 4'b0000);
      n_checks++;
      if (reg1 !== 32'hAA22CC44) begin
         n_fail++;
         $display("FAIL strobe_zero: reg1 %h, expected aa22cc44", reg1);
      end
      axi_read(4'h4, 32'hAA22CC44);
   endtask

   task automatic test_aw_early();
      @(negedge clk);
      awaddr = 4'h0; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1;
      wr_exp_q.push_back(4'b0001);
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (awready !== 1'b0 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL aw_alone: awready %b wready %b, expected 0 0", awready, wready);
         end
      end
      wvalid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (awready !== 1'b1 || wready !== 1'b1) begin
         n_fail++;
         $display("FAIL aw_w_accept: awready %b wready %b, expected 1 1", awready, wready);
      end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b1 || reg0 !== 32'h77) begin
         n_fail++;
         $display("FAIL aw_early_b: bvalid %b reg0 %h, expected 1 00000077", bvalid, reg0);
      end
      @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (bvalid !== 1'b0 || awready !== 1'b0) begin
            n_fail++;
            $display("FAIL aw_early_single: bvalid %b awready %b, expected 0 0", bvalid, awready);
         end
      end
   endtask

   task automatic test_bready_stall();
      int cyc;
      bready = 1'b0;
      @(negedge clk);
      awaddr = 4'hC; wdata = 32'hA5A50001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      wr_exp_q.push_back(4'b1000);
      @(negedge clk);
      @(negedge clk);
      wdata = 32'h0000BEEF;
      wr_exp_q.push_back(4'b1000);
      repeat (5) begin
         n_checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0 || reg3 !== 32'hA5A50001) begin
            n_fail++;
            $display("FAIL b_stall: bvalid %b awready %b reg3 %h, expected 1 0 a5a50001",
                     bvalid, awready, reg3);
         end
         @(negedge clk);
      end
      bready = 1'b1;
      cyc = 0;
      while (!awready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc >= 20) begin
         n_fail++;
         $display("FAIL b_stall_second_accept: not accepted in 20 cycles");
      end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b1 || reg3 !== 32'h0000BEEF) begin
         n_fail++;
         $display("FAIL b_stall_second: bvalid %b reg3 %h, expected 1 0000beef", bvalid, reg3);
      end
      @(negedge clk);
   endtask

   task automatic test_read_stall();
      logic [31:0] e;
      axi_write(4'h8, 32'h3, 4'hF);
      rready = 1'b0;
      @(negedge clk);
      araddr = 4'h8; arvalid = 1'b1;
      rd_exp_q.push_back(32'h3);
      awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      wr_exp_q.push_back(4'b0100);
      @(negedge clk);
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      e = rd_exp_q.pop_front();
      repeat (4) begin
         n_checks++;
         if (rvalid !== 1'b1 || rdata !== e) begin
            n_fail++;
            $display("FAIL r_stall: rvalid %b rdata %h, expected 1 %h", rvalid, rdata, e);
         end
         @(negedge clk);
      end
      n_checks++;
      if (reg2 !== 32'h9) begin
         n_fail++;
         $display("FAIL r_stall_write: reg2 %h, expected 00000009", reg2);
      end
      rready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL r_stall_release: rvalid %b, expected 0", rvalid);
      end
      axi_read(4'h8, 32'h9);
   endtask

   task automatic test_reset_mid();
      axi_write(4'h0, 32'h5, 4'hF);
      bready = 1'b0;
      @(negedge clk);
      awaddr = 4'h4; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      wr_exp_q.push_back(4'b0010);
      @(negedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b1 || reg0 !== 32'h5) begin
         n_fail++;
         $display("FAIL reset_mid_setup: bvalid %b reg0 %h, expected 1 00000005", bvalid, reg0);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bvalid !== 1'b0 || reg0 !== 32'h0 || reg1 !== 32'h0 || awready !== 1'b0 ||
          reg_wr !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_mid_async: bvalid %b reg0 %h reg1 %h awready %b reg_wr %b, expected all zero",
                  bvalid, reg0, reg1, awready, reg_wr);
      end
      bready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_b: bvalid %b, expected 0", bvalid);
         end
      end
      axi_write(4'h4, 32'h00001234, 4'hF);
      axi_read(4'h4, 32'h00001234);
      axi_read(4'h0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_strobe();
      test_aw_early();
      test_bready_stall();
      test_read_stall();
      test_reset_mid();
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d pulses and %0d reads left, expected 0 0",
                  wr_exp_q.size(), rd_exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
